alu_multicycle: RTL and testbench

//  Parametrised successor to the single-cycle execute ALU. Registered, handshaked

---
 rtl/alu_multicycle.sv | 121 ++++++++++++
 tb/tb_alu_multicycle.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked RISC-V integer ALU with iterative MUL/MULHU; DIVU/REMU only when ALU_DIV_EN is defined
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Src_A,
    input  logic [WIDTH-1:0] Src_B,
    input  logic [3:0]       ALUControl,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Op_Err
);
    localparam int SHW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_hi, r_lo, r_res, w_simple, w_hi, w_lo, w_mres;
    logic [WIDTH:0] w_sum;
    logic [SHW-1:0] r_cnt, w_sh;
    logic r_sel, r_zero, r_err, w_multi, w_illegal, w_accept, w_fin;
`ifdef ALU_DIV_EN
    logic r_div, w_ge;
    logic [WIDTH:0] w_t;
    assign w_multi = ALUControl[3:1] == 3'b101 || ALUControl[3:1] == 3'b110;
    assign w_illegal = ALUControl[3:1] == 3'b111;
`else
    assign w_multi = ALUControl[3:1] == 3'b101;
    assign w_illegal = ALUControl[3:2] == 2'b11;
`endif
    assign w_accept = In_Valid && r_state == IDLE;
    assign w_fin = &r_cnt;
    assign w_mres = r_sel ? w_hi : w_lo;
    assign In_Ready = r_state == IDLE;
    assign Out_Valid = r_state == DONE;
    assign ALUResult = r_res;
    assign Zero = r_zero;
    assign Op_Err = r_err;

    // single-cycle result from the live operands; iterative and reserved opcodes yield 0 here
    always_comb begin
        w_sh = Src_B[SHW-1:0];
        case (ALUControl)
            4'b0000: w_simple = Src_A + Src_B;
            4'b0001: w_simple = Src_A - Src_B;
            4'b0010: w_simple = Src_A & Src_B;
            4'b0011: w_simple = Src_A | Src_B;
            4'b0100: w_simple = $signed(Src_A) >>> w_sh;
            4'b0101: w_simple = {{(WIDTH-1){1'b0}}, $signed(Src_A) < $signed(Src_B)};
            4'b0110: w_simple = Src_A ^ Src_B;
            4'b0111: w_simple = Src_A << w_sh;
            4'b1000: w_simple = Src_A >> w_sh;
            4'b1001: w_simple = {{(WIDTH-1){1'b0}}, Src_A < Src_B};
            default: w_simple = '0;
        endcase
    end

    // one shift-add multiply step (hi:lo = partial product:multiplier) or one restoring divide step (hi:lo = remainder:quotient)
    always_comb begin
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_hi = w_sum[WIDTH:1];
        w_lo = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        w_t = {r_hi, r_lo[WIDTH-1]};
        w_ge = w_t >= {1'b0, r_a};
        if (r_div) begin
            w_hi = w_ge ? w_t[WIDTH-1:0] - r_a : w_t[WIDTH-1:0];
            w_lo = {r_lo[WIDTH-2:0], w_ge};
        end
`endif
    end

    // next state: iterative ops spend WIDTH cycles in BUSY, everything else goes straight to DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = In_Valid ? (w_multi ? BUSY : DONE) : IDLE;
            BUSY:    w_next = w_fin ? DONE : BUSY;
            DONE:    w_next = Out_Ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // state, operand capture, iteration and result registers; the last iteration writes the result directly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_res <= '0;
            r_zero <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a <= Src_B;
                r_hi <= '0;
                r_lo <= Src_A;
                r_sel <= ALUControl[0];
`ifdef ALU_DIV_EN
                r_div <= ALUControl[2];
`endif
                r_cnt <= '0;
                r_res <= w_simple;
                r_zero <= w_simple == '0;
                r_err <= w_illegal;
            end else if (r_state == BUSY) begin
                r_hi <= w_hi;
                r_lo <= w_lo;
                r_cnt <= r_cnt + 1'b1;
                if (w_fin) begin
                    r_res <= w_mres;
                    r_zero <= w_mres == '0;
                    r_err <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized self-checking bench against a transaction-level ALU model (honours ALU_DIV_EN)
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic reset, In_Valid, In_Ready, Out_Valid, Out_Ready, Zero, Op_Err;
    logic [31:0] Src_A, Src_B, ALUResult;
    logic [3:0] ALUControl;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit m_busy = 1'b0;
    int m_cnt = 0;
    int m_lat = 1;
    logic [31:0] m_res = '0;
    logic m_err = 1'b0;
    logic [31:0] g;
    logic gz, ge;
    int lt;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Src_A(Src_A), .Src_B(Src_B), .ALUControl(ALUControl),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .ALUResult(ALUResult), .Zero(Zero), .Op_Err(Op_Err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [63:0] p;
        logic [31:0] r;
        logic e;
        p = {32'b0, a} * {32'b0, b};
        r = '0;
        e = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = $signed(a) >>> b[4:0];
            4'd5:  r = {31'b0, $signed(a) < $signed(b)};
            4'd6:  r = a ^ b;
            4'd7:  r = a << b[4:0];
            4'd8:  r = a >> b[4:0];
            4'd9:  r = {31'b0, a < b};
            4'd10: r = p[31:0];
            4'd11: r = p[63:32];
`ifdef ALU_DIV_EN
            4'd12: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd13: r = (b == 32'd0) ? a : a % b;
`endif
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op >= 4'd10 && op <= 4'd13) ? 33 : 1;
`else
        return (op == 4'd10 || op == 4'd11) ? 33 : 1;
`endif
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic pin(input string n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] e_res, input logic e_err);
        logic [32:0] r;
        r = ref_alu(a, b, op);
        chk(n, r[31:0], e_res);
        chk({n, "_err"}, 32'(r[32]), 32'(e_err));
    endtask

    // model: one outstanding op, result visible once ref_lat cycles have elapsed, retired on Out_Ready
    always @(posedge clk) begin
        if (reset) m_busy <= 1'b0;
        else if (m_busy) begin
            if (m_cnt < m_lat) m_cnt <= m_cnt + 1;
            else if (Out_Ready) m_busy <= 1'b0;
        end else if (In_Valid) begin
            m_busy <= 1'b1;
            m_cnt <= 1;
            m_lat <= ref_lat(ALUControl);
            {m_err, m_res} <= ref_alu(Src_A, Src_B, ALUControl);
        end
    end

    // every cycle: handshake flags always, payload whenever a result is due
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(In_Ready), 32'(!m_busy));
            chk("out_valid", 32'(Out_Valid), 32'(m_busy && m_cnt >= m_lat));
            if (m_busy && m_cnt >= m_lat) begin
                chk("result", ALUResult, m_res);
                chk("zero", 32'(Zero), 32'(m_res == 32'd0));
                chk("op_err", 32'(Op_Err), 32'(m_err));
            end
        end
    end

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input int hold, input bit rnd,
                       output logic [31:0] got, output logic gzo, output logic geo, output int lat);
        int h;
        h = hold;
        got = '0;
        gzo = 1'b0;
        geo = 1'b0;
        lat = 0;
        Src_A = a;
        Src_B = b;
        ALUControl = op;
        In_Valid = 1'b1;
        Out_Ready = 1'b1;
        @(negedge clk);
        In_Valid = 1'b0;
        chk("accept", 32'(m_busy), 32'd1);
        for (int i = 0; i < 200 && m_busy; i++) begin
            if (Out_Valid === 1'b1 && lat == 0) begin
                got = ALUResult;
                gzo = Zero;
                geo = Op_Err;
                lat = i + 1;
            end
            Src_A = $urandom;
            Src_B = $urandom;
            ALUControl = 4'($urandom);
            if (m_cnt >= m_lat && h > 0) begin
                Out_Ready = 1'b0;
                h--;
            end else Out_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        chk("drain", 32'(m_busy), 32'd0);
        Out_Ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: no finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        reset = 1'b1;
        In_Valid = 1'b0;
        Src_A = '0;
        Src_B = '0;
        ALUControl = '0;
        Out_Ready = 1'b1;
        pin("pin_add", 32'hFFFF_FFFF, 32'h1, 4'd0, 32'h0, 1'b0);
        pin("pin_sra", 32'h8000_0000, 32'h21, 4'd4, 32'hC000_0000, 1'b0);
        pin("pin_srl", 32'h8000_0000, 32'h21, 4'd8, 32'h4000_0000, 1'b0);
        pin("pin_slt", 32'hFFFF_FFFF, 32'h1, 4'd5, 32'h1, 1'b0);
        pin("pin_sltu", 32'hFFFF_FFFF, 32'h1, 4'd9, 32'h0, 1'b0);
        pin("pin_mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'hFFFF_FFFE, 1'b0);
        pin("pin_mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'h1, 1'b0);
        pin("pin_rsv", 32'h5, 32'h6, 4'd14, 32'h0, 1'b1);
`ifdef ALU_DIV_EN
        pin("pin_divu", 32'd100, 32'd7, 4'd12, 32'd14, 1'b0);
        pin("pin_remu", 32'd100, 32'd7, 4'd13, 32'd2, 1'b0);
        pin("pin_div0", 32'd9, 32'd0, 4'd12, 32'hFFFF_FFFF, 1'b0);
`else
        pin("pin_divu", 32'd100, 32'd7, 4'd12, 32'd0, 1'b1);
`endif
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd0);
        chk("rst_err", 32'(Op_Err), 32'd0);
        chk("rst_valid", 32'(Out_Valid), 32'd0);
        chk("rst_ready", 32'(In_Ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        run(32'hFFFF_FFFF, 32'h1, 4'd0, 0, 1'b0, g, gz, ge, lt);
        chk("add_wrap", g, 32'd0);
        chk("add_zero", 32'(gz), 32'd1);
        chk("add_lat", 32'(lt), 32'd1);
        run(32'h8000_0000, 32'h21, 4'd4, 0, 1'b0, g, gz, ge, lt);
        chk("sra", g, 32'hC000_0000);
        run(32'h8000_0000, 32'h21, 4'd8, 0, 1'b0, g, gz, ge, lt);
        chk("srl", g, 32'h4000_0000);
        run(32'hFFFF_FFFF, 32'h1, 4'd5, 0, 1'b0, g, gz, ge, lt);
        chk("slt", g, 32'h1);
        run(32'hFFFF_FFFF, 32'h1, 4'd9, 0, 1'b0, g, gz, ge, lt);
        chk("sltu", g, 32'h0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 0, 1'b0, g, gz, ge, lt);
        chk("mulhu", g, 32'hFFFF_FFFE);
        chk("mulhu_lat", 32'(lt), 32'd33);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 0, 1'b0, g, gz, ge, lt);
        chk("mul", g, 32'h1);
`ifdef ALU_DIV_EN
        run(32'd100, 32'd7, 4'd12, 0, 1'b0, g, gz, ge, lt);
        chk("divu", g, 32'd14);
        chk("divu_lat", 32'(lt), 32'd33);
        run(32'd100, 32'd7, 4'd13, 0, 1'b0, g, gz, ge, lt);
        chk("remu", g, 32'd2);
        run(32'h1234_5678, 32'd0, 4'd12, 0, 1'b0, g, gz, ge, lt);
        chk("divu_by0", g, 32'hFFFF_FFFF);
        chk("divu_by0_lat", 32'(lt), 32'd33);
        run(32'h1234_5678, 32'd0, 4'd13, 0, 1'b0, g, gz, ge, lt);
        chk("remu_by0", g, 32'h1234_5678);
`else
        run(32'd100, 32'd7, 4'd12, 0, 1'b0, g, gz, ge, lt);
        chk("divu_off", g, 32'd0);
        chk("divu_off_err", 32'(ge), 32'd1);
        chk("divu_off_lat", 32'(lt), 32'd1);
`endif
        run(32'h5, 32'h6, 4'd15, 0, 1'b0, g, gz, ge, lt);
        chk("rsv_res", g, 32'd0);
        chk("rsv_zero", 32'(gz), 32'd1);
        chk("rsv_err", 32'(ge), 32'd1);
        chk("rsv_lat", 32'(lt), 32'd1);
        run(32'd12345, 32'd678, 4'd10, 5, 1'b0, g, gz, ge, lt);
        chk("stall_mul", g, 32'd8369910);
        Src_A = 32'hFFFF_FFFF;
        Src_B = 32'h3;
        ALUControl = 4'd10;
        In_Valid = 1'b1;
        @(negedge clk);
        In_Valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        In_Valid = 1'b1;
        ALUControl = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        In_Valid = 1'b0;
        chk("rst_busy_ready", 32'(In_Ready), 32'd1);
        chk("rst_busy_valid", 32'(Out_Valid), 32'd0);
        chk("rst_busy_result", ALUResult, 32'd0);
        @(negedge clk);
        Src_A = 32'd1;
        Src_B = 32'd2;
        ALUControl = 4'd0;
        In_Valid = 1'b1;
        Out_Ready = 1'b0;
        @(negedge clk);
        In_Valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Out_Ready = 1'b1;
        chk("rst_done_valid", 32'(Out_Valid), 32'd0);
        chk("rst_done_ready", 32'(In_Ready), 32'd1);
        for (int n = 0; n < 250; n++) begin
            a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run(a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b1, g, gz, ge, lt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
